// File: rtl/vector_line_gen.sv
// vector_line_gen
//   Buffers line segments in a small FIFO and walks each one with a Bresenham
//   stepper. It emits one beam point per DAC update period as a paced stream
//   for the vector DAC driver.
// Ports
//   clock, reset_n    system clock; synchronous active-low reset
//   flush             synchronous clear: empties the FIFO and aborts the segment
//   seg_valid/ready   segment input handshake
//   seg_x0..seg_i     segment endpoints (12-bit unsigned), colour, intensity
//   seg_blank         1 = blanked beam move, 0 = drawn
//   dac_x..dac_i      point data to the DAC driver
//   dac_latch         one-cycle strobe per point, fans out to every dac_*_latch
//   blank_out         to the DAC driver's blank_in
//   busy              FIFO non-empty or stepper active
//   dbg_state         current FSM state (0 IDLE, 1 LOAD, 2 STEP, 3 SETTLE)
// Handshake: a segment transfers in any cycle where seg_valid && seg_ready is
// sampled high at the clock edge and flush is low. seg_ready depends only on
// FIFO occupancy, never on seg_valid, so the producer may hold seg_valid and
// its data until it sees the transfer.
module vector_line_gen #(
  parameter int FIFO_DEPTH   = 8,
  parameter int UPDATE_DIV   = 37,
  parameter int SETTLE_TICKS = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        seg_valid,
  output logic        seg_ready,
  input  logic [11:0] seg_x0,
  input  logic [11:0] seg_y0,
  input  logic [11:0] seg_x1,
  input  logic [11:0] seg_y1,
  input  logic [11:0] seg_r,
  input  logic [11:0] seg_g,
  input  logic [11:0] seg_b,
  input  logic [11:0] seg_i,
  input  logic        seg_blank,
  output logic [11:0] dac_x,
  output logic [11:0] dac_y,
  output logic [11:0] dac_r,
  output logic [11:0] dac_g,
  output logic [11:0] dac_b,
  output logic [11:0] dac_i,
  output logic        dac_latch,
  output logic        blank_out,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(UPDATE_DIV);
  localparam int SEG_W = 97;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_STEP = 2'd2, S_SETTLE = 2'd3} state_t;

  // Update-period pacing: free-running, only reset_n restarts the phase.
  logic [CW-1:0] cnt_q;
  logic          tick;
  assign tick = (cnt_q == CW'(UPDATE_DIV - 1));

  always_ff @(posedge clock) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= tick ? '0 : cnt_q + CW'(1);
  end

  // Segment FIFO. Entry layout: {blank, i, b, g, r, y1, x1, y0, x0}.
  logic [SEG_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             empty, full, wr_en, rd_en;
  state_t           state_q, state_d;

  assign empty     = (count_q == '0);
  assign full      = (count_q == (AW+1)'(FIFO_DEPTH));
  assign seg_ready = !full;
  assign wr_en     = seg_valid && !full && !flush;
  assign rd_en     = (state_q == S_IDLE) && !empty && !flush;
  assign count_d   = flush ? '0 : count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= {seg_blank, seg_i, seg_b, seg_g, seg_r, seg_y1, seg_x1, seg_y0, seg_x0};
  end

  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Working segment and stepper state
  logic [SEG_W-1:0]  seg_q, seg_d;
  logic [11:0]       cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [11:0]       dx_q, dx_d, dy_q, dy_d;
  logic              sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
  logic signed [13:0] err_q, err_d;
  logic [3:0]        settle_q, settle_d;
  logic [11:0]       dac_x_q, dac_x_d, dac_y_q, dac_y_d, dac_r_q, dac_r_d;
  logic [11:0]       dac_g_q, dac_g_d, dac_b_q, dac_b_d, dac_i_q, dac_i_d;
  logic              latch_q, latch_d, blank_q, blank_d;

  logic [11:0] w_x0, w_y0, w_x1, w_y1, w_r, w_g, w_b, w_i;
  logic        w_blank;
  assign {w_blank, w_i, w_b, w_g, w_r, w_y1, w_x1, w_y0, w_x0} = seg_q;

  // Bresenham error terms; e2 = 2*err fits 14 bits signed for 12-bit spans.
  logic signed [13:0] dx_s, dy_s, e2;
  assign dx_s = {2'b00, dx_q};
  assign dy_s = {2'b00, dy_q};
  assign e2   = {err_q[12:0], 1'b0};

  always_comb begin
    state_d  = state_q;
    seg_d    = seg_q;
    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    err_d    = err_q;
    settle_d = settle_q;
    dac_x_d  = dac_x_q;
    dac_y_d  = dac_y_q;
    dac_r_d  = dac_r_q;
    dac_g_d  = dac_g_q;
    dac_b_d  = dac_b_q;
    dac_i_d  = dac_i_q;
    latch_d  = 1'b0;
    blank_d  = blank_q;
    if (flush) begin
      state_d = S_IDLE;
      blank_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          blank_d = 1'b1;
          if (rd_en) begin
            seg_d   = mem_q[rd_ptr_q];
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          sx_neg_d = (w_x1 < w_x0);
          sy_neg_d = (w_y1 < w_y0);
          dx_d     = sx_neg_d ? w_x0 - w_x1 : w_x1 - w_x0;
          dy_d     = sy_neg_d ? w_y0 - w_y1 : w_y1 - w_y0;
          err_d    = $signed({2'b00, dx_d}) - $signed({2'b00, dy_d});
          cur_x_d  = w_x0;
          cur_y_d  = w_y0;
          state_d  = S_STEP;
        end
        S_STEP: begin
          if (tick) begin
            latch_d = 1'b1;
            dac_x_d = cur_x_q;
            dac_y_d = cur_y_q;
            dac_r_d = w_r;
            dac_g_d = w_g;
            dac_b_d = w_b;
            dac_i_d = w_i;
            blank_d = w_blank;
            if (cur_x_q == w_x1 && cur_y_q == w_y1) begin
              settle_d = '0;
              state_d  = (SETTLE_TICKS == 0) ? S_IDLE : S_SETTLE;
            end else begin
              // Both axis updates may apply in one step (diagonal move).
              err_d = err_q;
              if (e2 >= -dy_s) begin
                err_d   = err_d - dy_s;
                cur_x_d = sx_neg_q ? cur_x_q - 12'd1 : cur_x_q + 12'd1;
              end
              if (e2 <= dx_s) begin
                err_d   = err_d + dx_s;
                cur_y_d = sy_neg_q ? cur_y_q - 12'd1 : cur_y_q + 12'd1;
              end
            end
          end
        end
        S_SETTLE: begin
          if (tick) begin
            if (settle_q == 4'(SETTLE_TICKS - 1)) begin
              state_d = S_IDLE;
              blank_d = 1'b1;
            end else begin
              settle_d = settle_q + 4'd1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      seg_q    <= '0;
      cur_x_q  <= '0;
      cur_y_q  <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
      err_q    <= '0;
      settle_q <= '0;
      dac_x_q  <= 12'h800;
      dac_y_q  <= 12'h800;
      dac_r_q  <= '0;
      dac_g_q  <= '0;
      dac_b_q  <= '0;
      dac_i_q  <= '0;
      latch_q  <= 1'b0;
      blank_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      seg_q    <= seg_d;
      cur_x_q  <= cur_x_d;
      cur_y_q  <= cur_y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
      err_q    <= err_d;
      settle_q <= settle_d;
      dac_x_q  <= dac_x_d;
      dac_y_q  <= dac_y_d;
      dac_r_q  <= dac_r_d;
      dac_g_q  <= dac_g_d;
      dac_b_q  <= dac_b_d;
      dac_i_q  <= dac_i_d;
      latch_q  <= latch_d;
      blank_q  <= blank_d;
    end
  end

  assign dac_x     = dac_x_q;
  assign dac_y     = dac_y_q;
  assign dac_r     = dac_r_q;
  assign dac_g     = dac_g_q;
  assign dac_b     = dac_b_q;
  assign dac_i     = dac_i_q;
  assign dac_latch = latch_q;
  assign blank_out = blank_q;
  assign busy      = !empty || (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_vector_line_gen.sv
// Testbench for vector_line_gen: drives segments, predicts every emitted point
// into an expected queue and compares each dac_latch against the queue head.
module tb_vector_line_gen;

  localparam int FIFO_DEPTH   = 8;
  localparam int UPDATE_DIV   = 37;
  localparam int SETTLE_TICKS = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        seg_valid = 1'b0;
  logic        seg_ready;
  logic [11:0] seg_x0 = '0, seg_y0 = '0, seg_x1 = '0, seg_y1 = '0;
  logic [11:0] seg_r = '0, seg_g = '0, seg_b = '0, seg_i = '0;
  logic        seg_blank = 1'b0;
  logic [11:0] dac_x, dac_y, dac_r, dac_g, dac_b, dac_i;
  logic        dac_latch, blank_out, busy;
  logic [1:0]  dbg_state;

  vector_line_gen #(
    .FIFO_DEPTH(FIFO_DEPTH), .UPDATE_DIV(UPDATE_DIV), .SETTLE_TICKS(SETTLE_TICKS)
  ) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .seg_valid(seg_valid), .seg_ready(seg_ready),
    .seg_x0(seg_x0), .seg_y0(seg_y0), .seg_x1(seg_x1), .seg_y1(seg_y1),
    .seg_r(seg_r), .seg_g(seg_g), .seg_b(seg_b), .seg_i(seg_i), .seg_blank(seg_blank),
    .dac_x(dac_x), .dac_y(dac_y), .dac_r(dac_r), .dac_g(dac_g), .dac_b(dac_b), .dac_i(dac_i),
    .dac_latch(dac_latch), .blank_out(blank_out), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock / reset-edge tracking
  always #5 clock = ~clock;

  logic rst_edge = 1'b1;
  always @(posedge clock) rst_edge <= !reset_n;

  // Scoreboard
  logic [96:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int latch_total = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [96:0] pt(input int x, input int y, input logic [11:0] r, g, b, i,
                                     input logic bl);
    return {bl, i, b, g, r, 12'(y), 12'(x)};
  endfunction

  // Reference line walk: pushes every expected point of one segment.
  task automatic model_seg(input int x0, y0, x1, y1, input logic [11:0] r, g, b, i,
                           input logic bl, output int n);
    int dx, dy, sx, sy, err, e2, x, y;
    dx = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy = (y1 > y0) ? y1 - y0 : y0 - y1;
    sx = (x1 >= x0) ? 1 : -1;
    sy = (y1 >= y0) ? 1 : -1;
    err = dx - dy;
    x = x0;
    y = y0;
    n = 0;
    while (n < 5000) begin
      exp_q.push_back(pt(x, y, r, g, b, i, bl));
      n++;
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= -dy) begin err -= dy; x += sx; end
      if (e2 <= dx)  begin err += dx; y += sy; end
    end
  endtask

  // Output monitor: point compare, pacing, hold-between-latches
  int cyc = 0;
  int last_cyc = 0;
  bit have_last = 0;
  bit have_prev = 0;
  logic [71:0] prev_data;
  logic [96:0] head;

  always @(negedge clock) begin
    cyc++;
    if (rst_edge) begin
      have_last = 0;
    end else if (dac_latch) begin
      latch_total++;
      if (have_last) check("latch_gap", 128'((cyc - last_cyc) % UPDATE_DIV), 128'(0));
      last_cyc  = cyc;
      have_last = 1;
      if (exp_q.size() == 0) begin
        check("unexpected_latch", 128'(1), 128'(0));
      end else begin
        head = exp_q.pop_front();
        check("point", 128'({blank_out, dac_i, dac_b, dac_g, dac_r, dac_y, dac_x}), 128'(head));
      end
    end else if (have_prev) begin
      check("hold", 128'({dac_i, dac_b, dac_g, dac_r, dac_y, dac_x}), 128'(prev_data));
    end
    prev_data = {dac_i, dac_b, dac_g, dac_r, dac_y, dac_x};
    have_prev = 1;
  end

  // Driver tasks
  task automatic send_seg(input logic [11:0] x0, y0, x1, y1, r, g, b, i, input logic bl);
    int k;
    k = 0;
    while (!seg_ready && k < 2000) begin @(negedge clock); k++; end
    check("send_ready", 128'(seg_ready), 128'(1));
    seg_x0 = x0; seg_y0 = y0; seg_x1 = x1; seg_y1 = y1;
    seg_r = r; seg_g = g; seg_b = b; seg_i = i; seg_blank = bl;
    seg_valid = 1'b1;
    @(negedge clock);
    seg_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin @(negedge clock); k++; end
    check("idle_reached", 128'(busy), 128'(0));
    check("idle_queue_empty", 128'(exp_q.size()), 128'(0));
    check("idle_blank", 128'(blank_out), 128'(1));
  endtask

  task automatic count_latches(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clock);
      if (dac_latch) n++;
    end
  endtask

  task automatic wait_latches(input int target, input int budget);
    int n, k;
    n = 0;
    k = 0;
    while (n < target && k < budget) begin
      @(negedge clock);
      k++;
      if (dac_latch) n++;
    end
    check("latch_wait", 128'(n), 128'(target));
  endtask

  // Main sequence
  int base, n, k, idx, acc_before_stall;

  initial begin
    repeat (3) @(negedge clock);
    check("rst_dac_x", 128'(dac_x), 128'(12'h800));
    check("rst_dac_y", 128'(dac_y), 128'(12'h800));
    check("rst_rgbi", 128'({dac_r, dac_g, dac_b, dac_i}), 128'(0));
    check("rst_latch", 128'(dac_latch), 128'(0));
    check("rst_blank", 128'(blank_out), 128'(1));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_ready", 128'(seg_ready), 128'(1));
    check("rst_state", 128'(dbg_state), 128'(0));
    reset_n = 1'b1;

    // 1: shallow line, explicit expected points
    base = latch_total;
    exp_q.push_back(pt(0, 0, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 1'b0));
    exp_q.push_back(pt(1, 0, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 1'b0));
    exp_q.push_back(pt(2, 1, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 1'b0));
    exp_q.push_back(pt(3, 1, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 1'b0));
    send_seg(12'd0, 12'd0, 12'd3, 12'd1, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 1'b0);
    wait_idle(20 * UPDATE_DIV);
    check("t1_latches", 128'(latch_total - base), 128'(4));

    // 2: degenerate segment, blank returns after settle
    base = latch_total;
    exp_q.push_back(pt(100, 100, 12'h123, 12'h456, 12'h789, 12'hABC, 1'b0));
    send_seg(12'd100, 12'd100, 12'd100, 12'd100, 12'h123, 12'h456, 12'h789, 12'hABC, 1'b0);
    k = 0;
    while (!dac_latch && k < 4 * UPDATE_DIV) begin @(negedge clock); k++; end
    check("t2_latch_seen", 128'(dac_latch), 128'(1));
    check("t2_blank_at_latch", 128'(blank_out), 128'(0));
    k = 0;
    while (!blank_out && k < 4 * UPDATE_DIV) begin @(negedge clock); k++; end
    check("t2_settle_cycles", 128'(k), 128'(SETTLE_TICKS * UPDATE_DIV));
    wait_idle(4 * UPDATE_DIV);
    check("t2_latches", 128'(latch_total - base), 128'(1));
    check("t2_hold_x", 128'(dac_x), 128'(100));

    // 3: steep line with negative x
    base = latch_total;
    model_seg(10, 20, 7, 26, 12'h010, 12'h020, 12'h030, 12'h040, 1'b0, n);
    check("t3_model_count", 128'(n), 128'(7));
    send_seg(12'd10, 12'd20, 12'd7, 12'd26, 12'h010, 12'h020, 12'h030, 12'h040, 1'b0);
    wait_idle(20 * UPDATE_DIV);
    check("t3_latches", 128'(latch_total - base), 128'(7));
    check("t3_last_xy", 128'({dac_x, dac_y}), 128'({12'd7, 12'd26}));

    // 4: back-to-back segments with seg_valid held
    base = latch_total;
    idx = 0;
    acc_before_stall = -1;
    k = 0;
    while (idx < 10 && k < 5000) begin
      seg_x0 = 12'(idx * 10); seg_y0 = 12'd5; seg_x1 = 12'(idx * 10 + 1); seg_y1 = 12'd6;
      seg_r = 12'(idx); seg_g = 12'(idx + 1); seg_b = 12'(idx + 2); seg_i = 12'(idx + 3);
      seg_blank = idx[0];
      seg_valid = 1'b1;
      if (seg_ready) begin
        model_seg(idx * 10, 5, idx * 10 + 1, 6, 12'(idx), 12'(idx + 1), 12'(idx + 2),
                  12'(idx + 3), idx[0], n);
        idx++;
      end else if (acc_before_stall < 0) begin
        acc_before_stall = idx;
      end
      @(negedge clock);
      k++;
    end
    seg_valid = 1'b0;
    check("t4_all_sent", 128'(idx), 128'(10));
    check("t4_stall_point", 128'(acc_before_stall), 128'(FIFO_DEPTH + 1));
    wait_idle(10 * 8 * UPDATE_DIV);
    check("t4_latches", 128'(latch_total - base), 128'(20));

    // 5: long blanked move, flush at point 5 with a same-cycle write
    model_seg(0, 0, 4094, 0, 12'h0, 12'h0, 12'h0, 12'h0, 1'b1, n);
    check("t5_model_count", 128'(n), 128'(4095));
    send_seg(12'd0, 12'd0, 12'd4094, 12'd0, 12'h0, 12'h0, 12'h0, 12'h0, 1'b1);
    wait_latches(5, 8 * UPDATE_DIV);
    check("t5_blank_drawing", 128'(blank_out), 128'(1));
    flush = 1'b1;
    seg_x0 = 12'd1; seg_y0 = 12'd1; seg_x1 = 12'd2; seg_y1 = 12'd2; seg_valid = 1'b1;
    @(posedge clock);
    #1;
    exp_q.delete();
    @(negedge clock);
    flush = 1'b0;
    seg_valid = 1'b0;
    check("t5_busy", 128'(busy), 128'(0));
    check("t5_blank", 128'(blank_out), 128'(1));
    check("t5_latch", 128'(dac_latch), 128'(0));
    check("t5_hold_x", 128'(dac_x), 128'(4));
    check("t5_ready", 128'(seg_ready), 128'(1));
    check("t5_state", 128'(dbg_state), 128'(0));
    count_latches(3 * UPDATE_DIV, n);
    check("t5_no_latches", 128'(n), 128'(0));

    // 6: reset pulse mid-segment
    model_seg(0, 0, 200, 0, 12'h111, 12'h222, 12'h333, 12'h444, 1'b0, n);
    send_seg(12'd0, 12'd0, 12'd200, 12'd0, 12'h111, 12'h222, 12'h333, 12'h444, 1'b0);
    wait_latches(3, 6 * UPDATE_DIV);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    exp_q.delete();
    @(negedge clock);
    reset_n = 1'b1;
    check("t6_dac_xy", 128'({dac_x, dac_y}), 128'({12'h800, 12'h800}));
    check("t6_blank", 128'(blank_out), 128'(1));
    check("t6_ready", 128'(seg_ready), 128'(1));
    check("t6_busy", 128'(busy), 128'(0));
    count_latches(3 * UPDATE_DIV, n);
    check("t6_no_latches", 128'(n), 128'(0));
    base = latch_total;
    model_seg(50, 60, 52, 57, 12'h0AA, 12'h0BB, 12'h0CC, 12'h0DD, 1'b0, n);
    send_seg(12'd50, 12'd60, 12'd52, 12'd57, 12'h0AA, 12'h0BB, 12'h0CC, 12'h0DD, 1'b0);
    wait_idle(20 * UPDATE_DIV);
    check("t6_after_latches", 128'(latch_total - base), 128'(4));
    check("t6_after_last", 128'({dac_x, dac_y}), 128'({12'd52, 12'd57}));

    check("final_queue_empty", 128'(exp_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
